// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main-memory port between the I-cache
// and the D-cache. The winner's command is registered onto the memory side
// and held until memory answers with mem_ready; only the winner sees ready.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; without
// it the D-cache always beats the I-cache.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        arb_grant
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_d_q, last_d_d;   // 1: D-cache held the previous grant
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic i_act, d_act, any_act, pick_d;

  assign i_act   = i_read | i_write;
  assign d_act   = d_read | d_write;
  assign any_act = i_act | d_act;

`ifdef MEM_ARB_RR_EN
  // Tie goes to whichever requester did not hold the last grant
  assign pick_d = d_act & (~i_act | ~last_d_q);
`else
  // Fixed priority: D-cache misses stall the pipeline harder, so D always wins
  assign pick_d = d_act;
`endif

  // State and command registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_d_q    <= last_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state: grant on any request, release on memory completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_act)   state_d = BUSY;
      BUSY:    if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, grant bookkeeping and ready steering
  always_comb begin
    grant_d     = grant_q;
    last_d_d    = last_d_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_act) begin
          // write has precedence when a cache raises both strobes
          grant_d     = pick_d ? 2'b10 : 2'b01;
          mem_write_d = pick_d ? d_write : i_write;
          mem_read_d  = pick_d ? (d_read & ~d_write) : (i_read & ~i_write);
          mem_addr_d  = pick_d ? d_addr  : i_addr;
          mem_wdata_d = pick_d ? d_wdata : i_wdata;
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      BUSY: begin
        i_ready = mem_ready & grant_q[0];
        d_ready = mem_ready & grant_q[1];
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          grant_d     = 2'b00;
          last_d_d    = grant_q[1];
        end
      end
      default: ;
    endcase
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_grant = grant_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. A transaction-level model
// decides each grant from the pending cache requests; a monitor compares the
// memory-side command and the per-cache ready/data against queued expectations.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset_n = 1'b0;
  logic          i_read = 0, i_write = 0, d_read = 0, d_write = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    arb_grant;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_grant(arb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    g;
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct packed {
    logic [1:0]    g;
    logic [DW-1:0] rd;
  } done_t;

  cmd_t  exp_q[$];
  done_t done_q[$];
  int    n_tests = 0, n_fail = 0;
  bit    resp_en = 1'b1;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: one outstanding memory transaction, picked from whichever
  // caches are requesting at the moment the port is free.
  bit m_busy = 0, m_win_d = 0, m_last_d = 0;
  always @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      m_busy = 0; m_last_d = 0;
      exp_q.delete(); done_q.delete();
    end else if (!m_busy) begin
      bit ia, da, use_d;
      cmd_t c;
      ia = i_read | i_write;
      da = d_read | d_write;
      if (ia || da) begin
`ifdef MEM_ARB_RR_EN
        use_d = da && (!ia || !m_last_d);
`else
        use_d = da;
`endif
        c.g  = use_d ? 2'b10 : 2'b01;
        c.wr = use_d ? d_write : i_write;
        c.rd = (use_d ? d_read : i_read) && !c.wr;
        c.a  = use_d ? d_addr : i_addr;
        c.wd = use_d ? d_wdata : i_wdata;
        exp_q.push_back(c);
        m_busy = 1; m_win_d = use_d;
      end
    end else if (mem_ready) begin
      m_busy = 0; m_last_d = m_win_d;
    end
  end

  // Memory responder: random latency while busy, occasional stray ready while idle
  initial begin
    bit armed = 0;
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (!proc_reset_n) armed = 0;
      else if (m_busy && !armed) begin
        armed = 1; wcnt = $urandom_range(0, 4);
      end else if (m_busy) begin
        if (resp_en) begin
          if (wcnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            done_q.push_back({(m_win_d ? 2'b10 : 2'b01), mem_rdata});
            armed = 0;
          end else wcnt--;
        end
      end else if (resp_en && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: new grant pops a command, held grant must stay constant,
  // ready/rdata must match the completion queue exactly.
  initial begin
    logic [1:0] prev_g = 2'b00;
    cmd_t cur = '0;
    forever begin
      @(negedge clk);
      if (!proc_reset_n) begin
        prev_g = 2'b00;
      end else begin
        bit new_g;
        new_g = (arb_grant != 2'b00) && (prev_g == 2'b00);
        if (new_g || exp_q.size() > 0) begin
          chk("grant_event", {159'd0, new_g}, {159'd0, exp_q.size() > 0});
          if (new_g && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("cmd", {arb_grant, mem_read, mem_write, mem_addr, mem_wdata}, cur);
          end
        end else if (arb_grant != 2'b00) begin
          chk("cmd_hold", {arb_grant, mem_read, mem_write, mem_addr, mem_wdata}, cur);
        end else begin
          chk("idle_strobes", {158'd0, mem_read, mem_write}, 160'd0);
        end
        if (i_ready || d_ready || done_q.size() > 0) begin
          done_t d;
          d = (done_q.size() > 0) ? done_q.pop_front() : '0;
          chk("ready", {158'd0, d_ready, i_ready}, {158'd0, d.g});
          if (d.g != 2'b00) chk("rdata", {32'd0, i_rdata}, {32'd0, d.rd});
          if (d.g != 2'b00) chk("rdata_bcast", {32'd0, d_rdata}, {32'd0, d.rd});
        end
        prev_g = arb_grant;
      end
    end
  end

  task automatic set_req(input bit is_d, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (is_d) begin d_read = rd; d_write = wr; d_addr = a; d_wdata = wd; end
    else      begin i_read = rd; i_write = wr; i_addr = a; i_wdata = wd; end
  endtask

  // One cache: level request held until its ready; address/data wander while
  // waiting, which the arbiter must ignore once it has granted.
  task automatic drive(input bit is_d, input int n);
    for (int k = 0; k < n; k++) begin
      bit rd, wr, got;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int t, idle, op;
      idle = (k < 3) ? 0 : $urandom_range(0, 3);
      repeat (idle) begin @(posedge clk); #1; end
      op = $urandom_range(0, 5);
      rd = (op != 3 && op != 4);
      wr = (op >= 3);
      a  = AW'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      if (is_d && k == 0) begin rd = 1; wr = 0; a = 28'h0000123; end
      if (is_d && k == 1) begin rd = 0; wr = 1; a = 28'h00000A0;
                                wd = 128'h1111_2222_3333_4444; end
      if (is_d && k == 2) begin rd = 1; wr = 0; a = 28'h00000C0; end
      if (!is_d && k == 0) begin rd = 1; wr = 0; end
      set_req(is_d, rd, wr, a, wd);
      got = 0; t = 0;
      while (!got && t < 200) begin
        @(negedge clk);
        got = is_d ? d_ready : i_ready;
        @(posedge clk); #1;
        if (!got && $urandom_range(0, 1) == 1) begin
          a  = AW'($urandom);
          wd = {$urandom, $urandom, $urandom, $urandom};
          set_req(is_d, rd, wr, a, wd);
        end
        t++;
      end
      if (!got) chk("ready_timeout", 160'd0, 160'd1);
      set_req(is_d, 1'b0, 1'b0, a, wd);
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {3'd0, mem_read, mem_write, arb_grant, i_ready, d_ready, mem_addr, mem_wdata},
        160'd0);
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    fork
      drive(1'b1, 40);
      drive(1'b0, 40);
    join
    repeat (12) @(posedge clk);
    #1;
    // Reset in the middle of a granted transaction
    resp_en = 1'b0;
    d_read = 1'b1; d_addr = 28'h0BEEF00;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = (arb_grant != 2'b00);
    end
    chk("rst_busy_reached", {159'd0, seen}, 160'd1);
    #2 proc_reset_n = 1'b0;
    #1 chk("rst_async", {157'd0, mem_read, mem_write, arb_grant}, 160'd0);
    d_read = 1'b0;
    @(posedge clk); #1;
    proc_reset_n = 1'b1;
    resp_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", 160'(exp_q.size() + done_q.size()), 160'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
